mem_stage: RTL

Memory-access stage of the five-stage pipeline. It holds the word-addressed data memory, performs loads and stores for the instruction currently in MEM, and registers the MEM/WB pipeline register whose outputs drive the write-back stage. The write-back stage selects between `walu` and `wmo` with `wm2reg` and writes register `wrn` when `wwreg` is set. Misaligned word accesses are suppressed and reported through a sticky error flag.

---
 rtl/mem_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage of the five-stage pipeline. Holds a word-addressed
// data memory, performs the load or store of the instruction in MEM, and
// registers the MEM/WB pipeline register feeding write-back.
//
// Ports:
//   clk      in   1   pipeline clock, rising edge
//   clrn     in   1   asynchronous active-low reset
//   mwreg    in   1   instruction writes a register
//   mm2reg   in   1   instruction is a load
//   mwmem    in   1   instruction is a store
//   malu     in  32   ALU result / byte address
//   mb       in  32   store data
//   mrn      in   5   destination register number
//   wwreg    out  1   registered register write enable
//   wm2reg   out  1   registered load select
//   walu     out 32   registered ALU result
//   wmo      out 32   registered memory read data
//   wrn      out  5   registered destination register number
//   mis_err  out  1   sticky misaligned-access flag
module mem_stage #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic [4:0]  wrn,
  output logic        mis_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] index;
  logic              aligned;
  logic [31:0]       mo;

  // Upper address bits are ignored, so accesses wrap around the memory.
  assign index   = malu[ADDR_W+1:2];
  assign aligned = (malu[1:0] == 2'b00);
  assign mo      = mem[index];

  // Memory and MEM/WB register share one edge. Because mo is sampled
  // before the write lands, a store (or an illegal load+store) captures
  // the pre-write word into wmo. The memory is cleared on reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wwreg   <= 1'b0;
      wm2reg  <= 1'b0;
      walu    <= '0;
      wmo     <= '0;
      wrn     <= '0;
      mis_err <= 1'b0;
    end else begin
      if (mwmem && aligned) begin
        mem[index] <= mb;
      end
      walu   <= malu;
      wmo    <= mo;
      wrn    <= mrn;
      wm2reg <= mm2reg;
      // A misaligned load becomes a bubble: it must not write a register.
      wwreg  <= mwreg & ~(mm2reg & ~aligned);
      // Only real memory accesses can flag misalignment.
      if ((mwmem || mm2reg) && !aligned) begin
        mis_err <= 1'b1;
      end
    end
  end

endmodule
